// File: rtl/spdif_bmc_tx_if.sv
// PCM sample-pair handshake between a sample source and the S/PDIF transmitter.
interface spdif_bmc_tx_if;
    logic [15:0] dataL;
    logic [15:0] dataR;
    logic        valid;
    logic        ready;

    modport master (output dataL, output dataR, output valid, input ready);
    modport slave  (input dataL, input dataR, input valid, output ready);
endinterface

// File: rtl/spdif_bmc_tx.sv
// S/PDIF biphase-mark transmitter: frames 16-bit L/R pairs into IEC 60958
// subframes and serialises them, one UI every CLK_DIV clocks.
module spdif_bmc_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [31:0] CS_WORD = 32'h0000_0000
) (
    input  logic          iClk,
    input  logic          iRst_n,
    spdif_bmc_tx_if.slave pcm,
    output logic          oSPDIF,
    output logic          oUnderrun,
    output logic          oBlockStart
);
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned UI_W       = 6;
    localparam int unsigned FRAME_W    = 8;
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(191);
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    logic [DIV_W-1:0]    div;
    logic [UI_W-1:0]     uiCnt;
    logic                chanR;
    logic [FRAME_W-1:0]  frame;
    logic [SAMPLE_W-1:0] holdL, holdR, actL, actR;
    logic                readyReg;
    logic                vFlag;
    logic                prePol;

    logic                uiStart;
    logic                frameLoad;
    logic [4:0]          slot;
    logic [SAMPLE_W-1:0] sample;
    logic                chBit;
    logic [7:0]          prePat;
    logic                prePolNow;
    logic                slotBit;
    logic                nextLevel;

    assign pcm.ready = readyReg;

    // Line level for the UI that starts this cycle.
    always_comb begin
        uiStart   = (div == '0);
        slot      = uiCnt[5:1];
        frameLoad = uiStart && (uiCnt == '0) && !chanR;
        sample    = chanR ? actR : actL;
        chBit     = (frame < FRAME_W'(32)) ? CS_WORD[frame[4:0]] : 1'b0;
        prePat    = chanR ? PRE_W : ((frame == '0) ? PRE_B : PRE_M);
        // Preamble polarity follows the level left on the line by the previous subframe.
        prePolNow = (uiCnt == '0) ? oSPDIF : prePol;
        slotBit   = 1'b0;
        if (slot >= 5'd12 && slot <= 5'd27) begin
            slotBit = sample[4'(slot - 5'd12)];
        end else if (slot == 5'd28) begin
            slotBit = vFlag;
        end else if (slot == 5'd30) begin
            slotBit = chBit;
        end else if (slot == 5'd31) begin
            slotBit = (^sample) ^ vFlag ^ chBit;
        end
        if (slot < 5'd4) begin
            nextLevel = prePat[~uiCnt[2:0]] ^ prePolNow;
        end else if (!uiCnt[0]) begin
            nextLevel = ~oSPDIF;
        end else begin
            nextLevel = oSPDIF ^ slotBit;
        end
    end

    // Divider, slot/frame sequencing, sample pipeline and line register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            div         <= '0;
            uiCnt       <= '0;
            chanR       <= 1'b0;
            frame       <= '0;
            holdL       <= '0;
            holdR       <= '0;
            actL        <= '0;
            actR        <= '0;
            readyReg    <= 1'b1;
            vFlag       <= 1'b0;
            prePol      <= 1'b0;
            oSPDIF      <= 1'b0;
            oUnderrun   <= 1'b0;
            oBlockStart <= 1'b0;
        end else begin
            oUnderrun   <= 1'b0;
            oBlockStart <= 1'b0;
            div <= (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);

            if (pcm.valid && readyReg) begin
                holdL    <= pcm.dataL;
                holdR    <= pcm.dataR;
                readyReg <= 1'b0;
            end

            if (uiStart) begin
                oSPDIF <= nextLevel;
                uiCnt  <= uiCnt + UI_W'(1);
                if (uiCnt == '0) begin
                    prePol <= oSPDIF;
                end
                if (uiCnt == '1) begin
                    chanR <= ~chanR;
                    if (chanR) begin
                        frame <= (frame == LAST_FRAME) ? '0 : frame + FRAME_W'(1);
                    end
                end
                // A pair accepted this same cycle is not yet visible here and waits a frame.
                if (frameLoad) begin
                    oBlockStart <= (frame == '0);
                    if (!readyReg) begin
                        actL     <= holdL;
                        actR     <= holdR;
                        vFlag    <= 1'b0;
                        readyReg <= 1'b1;
                    end else begin
                        actL      <= '0;
                        actR      <= '0;
                        vFlag     <= 1'b1;
                        oUnderrun <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spdif_bmc_tx.sv
// Directed bench for spdif_bmc_tx: records the line per clock and decodes
// preambles, biphase bits and handshake timing against hand-derived values.
module tb_spdif_bmc_tx;
    localparam int unsigned CLK_DIV = 2;
    localparam logic [31:0] CS      = 32'h0000_0005;
    localparam int          SUB_CYC = 64 * CLK_DIV;
    localparam int          FRM_CYC = 2 * SUB_CYC;
    localparam int          DEPTH   = 65536;

    logic iClk   = 1'b0;
    logic iRst_n = 1'b0;
    logic oSPDIF, oUnderrun, oBlockStart;

    spdif_bmc_tx_if pcm ();

    spdif_bmc_tx #(.CLK_DIV(CLK_DIV), .CS_WORD(CS)) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .pcm         (pcm),
        .oSPDIF      (oSPDIF),
        .oUnderrun   (oUnderrun),
        .oBlockStart (oBlockStart)
    );

    always #5 iClk = ~iClk;

    int   nTests = 0;
    int   nFail  = 0;
    int   cyc    = -1;
    logic lineArr [0:DEPTH-1];
    logic undArr  [0:DEPTH-1];
    logic bsArr   [0:DEPTH-1];
    logic rdyArr  [0:DEPTH-1];

    // Cycle 0 is the first cycle after the first edge following reset release.
    always @(posedge iClk) cyc <= iRst_n ? cyc + 1 : -1;

    always @(negedge iClk) begin
        if (cyc >= 0 && cyc < DEPTH) begin
            lineArr[16'(cyc)] <= oSPDIF;
            undArr[16'(cyc)]  <= oUnderrun;
            bsArr[16'(cyc)]   <= oBlockStart;
            rdyArr[16'(cyc)]  <= pcm.ready;
        end
    end

    function automatic logic ln(input int i);
        return lineArr[16'(i)];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) @(negedge iClk);
    endtask

    // Decode subframe s (0 = frame 0 left) and compare with its expected content.
    task automatic checkSub(input int s, input logic [15:0] smp, input logic v, input logic c);
        int          base, fr, u;
        logic        prev, holdOk, togOk;
        logic [7:0]  pat, obs;
        logic [27:0] bits, expb;
        base = 64 * s;
        fr   = (s / 2) % 192;
        prev = (s == 0) ? 1'b0 : ln(2 * base - 1);
        pat  = (s % 2 == 1) ? 8'b1110_0100 : ((fr == 0) ? 8'b1110_1000 : 8'b1110_0010);
        pat  = pat ^ {8{prev}};
        for (int k = 0; k < 8; k++) obs[3'(7 - k)] = ln(2 * (base + k));
        holdOk = 1'b1;
        for (int k = 0; k < 64; k++)
            if (ln(2 * (base + k)) !== ln(2 * (base + k) + 1)) holdOk = 1'b0;
        togOk = 1'b1;
        bits  = '0;
        for (int sl = 4; sl < 32; sl++) begin
            u = base + 2 * sl;
            if (ln(2 * u) === ln(2 * u - 2)) togOk = 1'b0;
            bits[5'(sl - 4)] = ln(2 * u) ^ ln(2 * u + 2);
        end
        expb = {(^smp) ^ v ^ c, c, 1'b0, v, smp, 8'h00};
        check($sformatf("sf%0d preamble", s), 32'(obs), 32'(pat));
        check($sformatf("sf%0d ui hold", s), 32'(holdOk), 32'd1);
        check($sformatf("sf%0d slot toggle", s), 32'(togOk), 32'd1);
        check($sformatf("sf%0d bits", s), 32'(bits), 32'(expb));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int acc[$];
        pcm.valid = 1'b0;
        pcm.dataL = '0;
        pcm.dataR = '0;
        repeat (3) @(negedge iClk);
        check("reset line", 32'(oSPDIF), 32'd0);
        check("reset ready", 32'(pcm.ready), 32'd1);
        check("reset underrun", 32'(oUnderrun), 32'd0);
        check("reset blockstart", 32'(oBlockStart), 32'd0);
        iRst_n = 1'b1;

        // Pair for frame 1.
        waitCyc(10);
        check("ready before accept", 32'(pcm.ready), 32'd1);
        pcm.dataL = 16'h8001;
        pcm.dataR = 16'h0000;
        pcm.valid = 1'b1;
        waitCyc(11);
        pcm.valid = 1'b0;
        check("ready after accept", 32'(pcm.ready), 32'd0);

        // Continuous valid with incrementing left samples from frame 2.
        waitCyc(300);
        pcm.dataR = 16'h00FF;
        k = 1;
        while (cyc < 1500) begin
            pcm.dataL = 16'(k);
            pcm.valid = 1'b1;
            if (pcm.ready) begin
                acc.push_back(cyc);
                k++;
            end
            @(negedge iClk);
        end
        pcm.valid = 1'b0;
        check("accept count", 32'(acc.size()), 32'd5);
        for (int i = 1; i + 1 < acc.size(); i++)
            check($sformatf("accept spacing %0d", i), 32'(acc[i + 1] - acc[i]), 32'(FRM_CYC));

        // Valid raised exactly on the frame-load cycle of frame 192 (block frame 0).
        waitCyc(192 * FRM_CYC - 1);
        check("ready at load cycle", 32'(pcm.ready), 32'd1);
        pcm.dataL = 16'h1234;
        pcm.dataR = 16'h5678;
        pcm.valid = 1'b1;
        waitCyc(192 * FRM_CYC);
        pcm.valid = 1'b0;
        check("ready after load-cycle accept", 32'(pcm.ready), 32'd0);
        waitCyc(388 * SUB_CYC + 4);

        check("underrun at cycle 0", 32'(undArr[0]), 32'd1);
        check("blockstart at cycle 0", 32'(bsArr[0]), 32'd1);
        check("underrun one cycle", 32'(undArr[1]), 32'd0);
        check("blockstart one cycle", 32'(bsArr[1]), 32'd0);
        checkSub(0, 16'h0000, 1'b1, 1'b1);
        checkSub(1, 16'h0000, 1'b1, 1'b1);
        check("ready before frame1 load", 32'(rdyArr[FRM_CYC - 1]), 32'd0);
        check("ready after frame1 load", 32'(rdyArr[FRM_CYC]), 32'd1);
        check("frame1 no underrun", 32'(undArr[FRM_CYC]), 32'd0);
        check("frame1 no blockstart", 32'(bsArr[FRM_CYC]), 32'd0);
        checkSub(2, 16'h8001, 1'b0, 1'b0);
        checkSub(3, 16'h0000, 1'b0, 1'b0);
        for (int f = 2; f <= 6; f++) begin
            check($sformatf("frame%0d no underrun", f), 32'(undArr[16'(f * FRM_CYC)]), 32'd0);
            checkSub(2 * f, 16'(f - 1), 1'b0, (f == 2));
            checkSub(2 * f + 1, 16'h00FF, 1'b0, (f == 2));
        end
        check("frame7 underrun", 32'(undArr[16'(7 * FRM_CYC)]), 32'd1);
        checkSub(14, 16'h0000, 1'b1, 1'b0);
        check("block restart blockstart", 32'(bsArr[16'(192 * FRM_CYC)]), 32'd1);
        check("load-cycle accept underruns", 32'(undArr[16'(192 * FRM_CYC)]), 32'd1);
        check("frame193 no underrun", 32'(undArr[16'(193 * FRM_CYC)]), 32'd0);
        checkSub(384, 16'h0000, 1'b1, 1'b1);
        checkSub(385, 16'h0000, 1'b1, 1'b1);
        checkSub(386, 16'h1234, 1'b0, 1'b0);
        checkSub(387, 16'h5678, 1'b0, 1'b0);

        // Reset mid-subframe with a pair held and the line high.
        pcm.dataL = 16'hBEEF;
        pcm.dataR = 16'hCAFE;
        pcm.valid = 1'b1;
        @(negedge iClk);
        pcm.valid = 1'b0;
        check("held pair before reset", 32'(pcm.ready), 32'd0);
        for (int i = 0; i < 16 && oSPDIF !== 1'b1; i++) @(negedge iClk);
        check("line high before reset", 32'(oSPDIF), 32'd1);
        @(posedge iClk);
        #1 iRst_n = 1'b0;
        #1;
        check("async reset line", 32'(oSPDIF), 32'd0);
        check("async reset ready", 32'(pcm.ready), 32'd1);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        waitCyc(FRM_CYC + 4);
        check("restart underrun", 32'(undArr[0]), 32'd1);
        check("restart blockstart", 32'(bsArr[0]), 32'd1);
        checkSub(0, 16'h0000, 1'b1, 1'b1);
        checkSub(1, 16'h0000, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
